// File: rtl/fb_fill_writer_pkg.sv
// Shared constants for the frame-buffer fill writer: MCB command codes,
// default frame-buffer geometry and bus widths.
package fb_fill_writer_pkg;

  localparam logic [2:0] MCB_INSTR_WRITE = 3'b000;
  localparam logic [2:0] MCB_INSTR_READ  = 3'b001;

  localparam int unsigned FB_ZERO_BASE  = 0;
  localparam int unsigned FB_ONE_BASE   = 614400;
  localparam int unsigned FB_BYTES      = 614400;
  localparam int unsigned FB_BURST_LEN  = 32;

  localparam int unsigned PIXEL_W    = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MASK_W     = 4;
  localparam int unsigned ADDR_W     = 30;
  localparam int unsigned BL_W       = 6;
  localparam int unsigned WR_COUNT_W = 7;
  localparam int unsigned BURST_W    = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CAL,
    ST_FILL,
    ST_CMD,
    ST_NEXT,
    ST_DONE
  } fill_state_e;

endpackage

// File: rtl/fb_fill_writer_if.sv
// MCB write port bundle: command path plus write-data FIFO.
//   master: the fill writer (drives cmd_* strobes/fields and wr_* data)
//   slave : the memory controller port (drives FIFO status and error flags)
interface fb_fill_writer_if;
  import fb_fill_writer_pkg::*;

  logic                  cmd_clk;
  logic                  cmd_en;
  logic [2:0]            cmd_instr;
  logic [BL_W-1:0]       cmd_bl;
  logic [ADDR_W-1:0]     cmd_byte_addr;
  logic                  cmd_empty;
  logic                  cmd_full;

  logic                  wr_clk;
  logic                  wr_en;
  logic [MASK_W-1:0]     wr_mask;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_full;
  logic                  wr_empty;
  logic [WR_COUNT_W-1:0] wr_count;
  logic                  wr_underrun;
  logic                  wr_error;

  modport master (
    output cmd_clk, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    output wr_clk, wr_en, wr_mask, wr_data,
    input  cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error
  );

  modport slave (
    input  cmd_clk, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    input  wr_clk, wr_en, wr_mask, wr_data,
    output cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error
  );

endinterface

// File: rtl/fb_fill_writer.sv
// Frame-buffer fill DMA: writes one whole buffer with a solid 16-bit colour
// through an MCB write port, one burst of data followed by its command.
//   Clk, Rst           clock and synchronous active-high reset
//   calib_done         MCB calibration complete (only checked before filling)
//   Start/FrameBuffer/FillColour  fill request, target buffer and colour
//   Busy/Done/Error    status: running, last-command pulse, sticky port error
//   mcb                MCB cmd + wr FIFO port (master side)
module fb_fill_writer
  import fb_fill_writer_pkg::*;
#(
  parameter int unsigned FrameBufferZeroStartAddress = FB_ZERO_BASE,
  parameter int unsigned FrameBufferOneStartAddress  = FB_ONE_BASE,
  parameter int unsigned FrameBufferBytes            = FB_BYTES,
  parameter int unsigned BurstLen                    = FB_BURST_LEN
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               calib_done,
  input  logic               Start,
  input  logic               FrameBuffer,
  input  logic [PIXEL_W-1:0] FillColour,
  output logic               Busy,
  output logic               Done,
  output logic               Error,
  fb_fill_writer_if.master   mcb
);

  localparam int unsigned TOTAL_WORDS = FrameBufferBytes / 4;

  fill_state_e         state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [BURST_W-1:0]  wcnt_q, wcnt_d;
  logic [BL_W-1:0]     bl_q, bl_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wr_push_c;
  logic                cmd_push_c;
  logic                unused_mcb;

  // Words in the next burst: BurstLen, or whatever is left for the final one.
  function automatic logic [BURST_W-1:0] min_burst(input logic [ADDR_W-1:0] rem);
    if (rem < ADDR_W'(BurstLen)) return BURST_W'(rem);
    return BURST_W'(BurstLen);
  endfunction

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    burst_d    = burst_q;
    wcnt_d     = wcnt_q;
    bl_d       = bl_q;
    cmd_addr_d = cmd_addr_q;
    data_d     = data_q;
    wr_push_c  = 1'b0;
    cmd_push_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_WAIT_CAL;
          busy_d  = 1'b1;
          error_d = 1'b0;
          addr_d  = FrameBuffer ? ADDR_W'(FrameBufferOneStartAddress)
                                : ADDR_W'(FrameBufferZeroStartAddress);
          rem_d   = ADDR_W'(TOTAL_WORDS);
          data_d  = {FillColour, FillColour};
        end
      end
      ST_WAIT_CAL: begin
        if (calib_done) begin
          state_d = ST_FILL;
          burst_d = min_burst(rem_q);
          wcnt_d  = '0;
        end
      end
      ST_FILL: begin
        // Push is gated by the live FIFO-full flag so no word is ever dropped.
        wr_push_c = !mcb.wr_full;
        if (wr_push_c) begin
          if (wcnt_q == burst_q - BURST_W'(1)) begin
            wcnt_d     = '0;
            bl_d       = BL_W'(burst_q - BURST_W'(1));
            cmd_addr_d = addr_q;
            state_d    = ST_CMD;
          end else begin
            wcnt_d = wcnt_q + BURST_W'(1);
          end
        end
      end
      ST_CMD: begin
        cmd_push_c = !mcb.cmd_full;
        if (cmd_push_c) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        rem_d  = rem_q - ADDR_W'(burst_q);
        addr_d = addr_q + (ADDR_W'(burst_q) << 2);
        if (rem_d == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FILL;
          burst_d = min_burst(rem_d);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Port errors are recorded but never abort the fill.
    if (mcb.wr_underrun || mcb.wr_error) error_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      burst_q    <= '0;
      wcnt_q     <= '0;
      bl_q       <= '0;
      cmd_addr_q <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      burst_q    <= burst_d;
      wcnt_q     <= wcnt_d;
      bl_q       <= bl_d;
      cmd_addr_q <= cmd_addr_d;
      data_q     <= data_d;
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Error = error_q;

  assign mcb.cmd_clk       = Clk;
  assign mcb.cmd_en        = cmd_push_c;
  assign mcb.cmd_instr     = MCB_INSTR_WRITE;
  assign mcb.cmd_bl        = bl_q;
  assign mcb.cmd_byte_addr = cmd_addr_q;
  assign mcb.wr_clk        = Clk;
  assign mcb.wr_en         = wr_push_c;
  assign mcb.wr_mask       = '0;
  assign mcb.wr_data       = data_q;

  // FIFO status that the fill sequencing does not need.
  assign unused_mcb = ^{mcb.cmd_empty, mcb.wr_empty, mcb.wr_count};

endmodule
